// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - control/data inputs and display outputs of seg_scan_mux
interface seg_scan_mux_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic                  load;
   logic [4*DIGITS-1:0]   data;
   logic [DIGITS-1:0]     blank;
   logic [DIGITS-1:0]     blink;
   logic [6:0]            seg;
   logic [DIGITS-1:0]     dig;
   logic                  scan_done;

   // master drives the nibbles and controls, slave is the scanner
   modport master (output en, load, data, blank, blink, input seg, dig, scan_done);
   modport slave  (input en, load, data, blank, blink, output seg, dig, scan_done);
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed seven-segment scanner with blank/blink
module seg_scan_mux #(
   parameter int DIGITS      = 4,
   parameter int DIV         = 50000,
   parameter int BLINK_SCANS = 64,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic           clk,
   input  logic           rst,
   seg_scan_mux_if.slave  bus
);
   localparam int CW = $clog2(DIV);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
   // XOR masks that turn an active-high pattern into pin levels
   localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW != 0}};
   localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{ACTIVE_LOW != 0}};

   logic [4*DIGITS-1:0] data_s;
   logic [DIGITS-1:0]   blank_s, blink_s;
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx, idx_nxt;
   logic [SW-1:0]       sc;
   logic                phase, phase_nxt;
   logic                started;
   logic                tick, last, wrap, sc_last, dark;
   logic [4*DIGITS-1:0] data_sh;
   logic [DIGITS-1:0]   blank_sh, blink_sh;
   logic [3:0]          nib;
   logic [6:0]          pat, seg_drv;
   logic [DIGITS-1:0]   dig_drv;
   logic [6:0]          seg_r;
   logic [DIGITS-1:0]   dig_r;
   logic                done_r;

   assign bus.seg       = seg_r;
   assign bus.dig       = dig_r;
   assign bus.scan_done = done_r;

   // slot timing, next digit selection and blink phase for the upcoming slot
   always_comb begin
      tick      = bus.en && (cnt == CW'(DIV - 1));
      last      = (idx == IW'(DIGITS - 1));
      idx_nxt   = last ? '0 : idx + 1'b1;
      // the reset-state idx is not a shown slot, so its
      // wrap into digit 0 does not count as a finished scan
      wrap      = tick && last && started;
      sc_last   = (sc == SW'(BLINK_SCANS - 1));
      phase_nxt = (wrap && sc_last) ? ~phase : phase;
      data_sh   = data_s >> {idx_nxt, 2'b00};
      blank_sh  = blank_s >> idx_nxt;
      blink_sh  = blink_s >> idx_nxt;
      nib       = data_sh[3:0];
      dark      = blank_sh[0] | (blink_sh[0] & phase_nxt);
   end

   // shared hex decoder, bit 0 = segment a, 1 = lit
   always_comb begin
      pat = 7'h00;
      case (nib)
         4'h0: pat = 7'h3F;
         4'h1: pat = 7'h06;
         4'h2: pat = 7'h5B;
         4'h3: pat = 7'h4F;
         4'h4: pat = 7'h66;
         4'h5: pat = 7'h6D;
         4'h6: pat = 7'h7D;
         4'h7: pat = 7'h07;
         4'h8: pat = 7'h7F;
         4'h9: pat = 7'h6F;
         4'hA: pat = 7'h77;
         4'hB: pat = 7'h7C;
         4'hC: pat = 7'h39;
         4'hD: pat = 7'h5E;
         4'hE: pat = 7'h79;
         4'hF: pat = 7'h71;
         default: pat = 7'h00;
      endcase
   end

   // apply blanking and output polarity
   always_comb begin
      seg_drv = (dark ? 7'h00 : pat) ^ SEG_OFF;
      dig_drv = (DIGITS'(1) << idx_nxt) ^ DIG_OFF;
   end

   // shadow registers, only written on load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_s  <= '0;
         blank_s <= '0;
         blink_s <= '0;
      end else if (bus.load) begin
         data_s  <= bus.data;
         blank_s <= bus.blank;
         blink_s <= bus.blink;
      end
   end

   // divider, digit index and blink scan counter; all hold while en=0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         idx     <= IW'(DIGITS - 1);
         sc      <= '0;
         phase   <= 1'b0;
         started <= 1'b0;
      end else if (tick) begin
         cnt     <= '0;
         idx     <= idx_nxt;
         started <= 1'b1;
         phase   <= phase_nxt;
         if (wrap) sc <= sc_last ? '0 : sc + 1'b1;
      end else if (bus.en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // registered pins: darken when disabled, reload on tick, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_r  <= SEG_OFF;
         dig_r  <= DIG_OFF;
         done_r <= 1'b0;
      end else begin
         done_r <= wrap;
         if (!bus.en) begin
            seg_r <= SEG_OFF;
            dig_r <= DIG_OFF;
         end else if (tick) begin
            seg_r <= seg_drv;
            dig_r <= dig_drv;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - scoreboard bench for seg_scan_mux
module tb_seg_scan_mux;
   localparam int DIGITS      = 4;
   localparam int DIV         = 4;
   localparam int BLINK_SCANS = 2;

   typedef struct {
      logic [3:0] dig;
      logic [6:0] seg;
      logic       done;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t sb[$];

   logic [15:0] m_data;
   logic [3:0]  m_blank, m_blink;
   int          m_idx;
   int          m_scan;

   always #5 clk = ~clk;

   seg_scan_mux_if #(.DIGITS(DIGITS)) bus ();

   seg_scan_mux #(
      .DIGITS(DIGITS), .DIV(DIV), .BLINK_SCANS(BLINK_SCANS), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   // active-low pin pattern (g..a) for each hex digit
   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   task automatic model_reset();
      m_data  = '0;
      m_blank = '0;
      m_blink = '0;
      m_idx   = 0;
      m_scan  = -1;
      sb.delete();
   endtask

   // push the expected contents of the next n digit slots
   task automatic push_slots(input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         bit   ph;
         if (m_idx == 0) m_scan++;
         ph     = ((m_scan / BLINK_SCANS) % 2) == 1;
         e.done = (m_idx == 0) && (m_scan > 0);
         e.dig  = ~(4'b0001 << m_idx);
         if (m_blank[m_idx] || (m_blink[m_idx] && ph))
            e.seg = 7'b1111111;
         else
            e.seg = ref_seg(m_data[4*m_idx +: 4]);
         sb.push_back(e);
         m_idx = (m_idx + 1) % DIGITS;
      end
   endtask

   // run n slots from the cycle before a tick, comparing every cycle
   task automatic drain_slots(input string name, input int n);
      for (int s = 0; s < n; s++) begin
         for (int c = 0; c < DIV; c++) begin
            @(negedge clk);
            n_cmp++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL %s: scoreboard empty at slot %0d", name, s);
            end else if ({bus.dig, bus.seg, bus.scan_done} !==
                         {sb[0].dig, sb[0].seg, (c == 0) ? sb[0].done : 1'b0}) begin
               n_fail++;
               $display("FAIL %s slot %0d cyc %0d: dig=%b seg=%b done=%b expected dig=%b seg=%b done=%b",
                        name, s, c, bus.dig, bus.seg, bus.scan_done,
                        sb[0].dig, sb[0].seg, (c == 0) ? sb[0].done : 1'b0);
            end
            bus.load = 1'b0;
         end
         if (sb.size() > 0) void'(sb.pop_front());
      end
   endtask

   task automatic expect_off(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus.dig, bus.seg, bus.scan_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            n_fail++;
            $display("FAIL %s off %0d: dig=%b seg=%b done=%b expected dig=1111 seg=1111111 done=0",
                     name, i, bus.dig, bus.seg, bus.scan_done);
         end
      end
   endtask

   task automatic test_reset();
      bus.en = 1'b0; bus.load = 1'b0; bus.data = '0; bus.blank = '0; bus.blink = '0;
      model_reset();
      expect_off("reset_held", 2);
      rst = 1'b0;
      bus.data = 16'h3210; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      m_data = 16'h3210;
      expect_off("load_disabled", 1);
      bus.en = 1'b1;
      expect_off("first_div", DIV - 1);
   endtask

   task automatic test_scan();
      push_slots(12);
      drain_slots("scan", 12);
   endtask

   task automatic test_load();
      bus.data = 16'hFFFF;
      push_slots(4);
      drain_slots("no_load", 4);
      bus.load = 1'b1;
      push_slots(1);
      m_data = 16'hFFFF;
      push_slots(4);
      drain_slots("load_at_tick", 5);
   endtask

   task automatic test_blank();
      bus.data = 16'h3210; bus.blank = 4'b0100; bus.load = 1'b1;
      push_slots(1);
      m_data = 16'h3210; m_blank = 4'b0100;
      push_slots(4);
      drain_slots("blank", 5);
   endtask

   task automatic test_blink();
      bus.blank = 4'b0000; bus.blink = 4'b0001; bus.load = 1'b1;
      push_slots(1);
      m_blank = 4'b0000; m_blink = 4'b0001;
      push_slots(20);
      drain_slots("blink", 21);
   endtask

   task automatic test_en_drop();
      exp_t e;
      push_slots(1);
      e = sb.pop_front();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({bus.dig, bus.seg, bus.scan_done} !== {e.dig, e.seg, (c == 0) ? e.done : 1'b0}) begin
            n_fail++;
            $display("FAIL en_drop pre cyc %0d: dig=%b seg=%b done=%b expected dig=%b seg=%b",
                     c, bus.dig, bus.seg, bus.scan_done, e.dig, e.seg);
         end
      end
      bus.en = 1'b0;
      expect_off("en_low", 10);
      bus.en = 1'b1;
      expect_off("en_resume", DIV - 2);
      push_slots(4);
      drain_slots("after_en", 4);
   endtask

   task automatic test_async_reset();
      push_slots(1);
      drain_slots("pre_rst", 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.dig, bus.seg, bus.scan_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
         n_fail++;
         $display("FAIL async_rst: dig=%b seg=%b done=%b expected dig=1111 seg=1111111 done=0",
                  bus.dig, bus.seg, bus.scan_done);
      end
      @(negedge clk);
      model_reset();
      rst = 1'b0;
      expect_off("post_rst", DIV - 1);
      push_slots(4);
      drain_slots("post_rst_scan", 4);
   endtask

   initial begin
      test_reset();
      test_scan();
      test_load();
      test_blank();
      test_blink();
      test_en_drop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
